// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encodings, decoder control bundle and its bubble value
package mips_pkg;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_R_TYPE = 2'd2;
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// hazard_unit: combinational load-use detection between the ID instruction and a load sitting in EX
//   in : i_id_valid, i_id_rs, i_id_rt, i_ex_valid, i_ex_mem_read, i_ex_wr_reg
//   out: o_hazard
module hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_wr_reg,
  output logic             o_hazard
);
  assign o_hazard = i_id_valid & i_ex_valid & i_ex_mem_read & (|i_ex_wr_reg) &
                    ((i_ex_wr_reg == i_id_rs) | (i_ex_wr_reg == i_id_rt));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubble and EX back-pressure hold
//   in : clk, rst, id_valid, id_* decoder controls/operands/indices, flush, ex_ready
//   out: stall, ex_valid, ex_* registered controls/operands/indices, ex_wr_reg
//   ID_EX_PERF_CNT_EN adds saturating perf_stall_cnt / perf_flush_cnt outputs
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_op,
  input  logic              id_reg_dst,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_2_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_jump,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        ex_alu_op,
  output logic              ex_reg_dst,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_mem_2_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_jump,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_wr_reg
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);
  ctrl_t             w_id_ctrl;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_pc_plus4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_wr_reg;
  logic              w_hazard;
  logic              w_bubble;
  assign w_id_ctrl = '{alu_op: id_alu_op, reg_dst: id_reg_dst, branch: id_branch,
                       mem_read: id_mem_read, mem_2_reg: id_mem_2_reg, mem_write: id_mem_write,
                       alu_src: id_alu_src, reg_write: id_reg_write, jump: id_jump};
  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .i_id_valid   (id_valid),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_ex_valid   (r_valid),
    .i_ex_mem_read(r_ctrl.mem_read),
    .i_ex_wr_reg  (r_wr_reg),
    .o_hazard     (w_hazard)
  );
  // flush wins over back-pressure; a hazard only bubbles when EX is actually advancing
  assign w_bubble = flush | (ex_ready & w_hazard);
  assign stall    = ~flush & (w_hazard | ~ex_ready);
  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_NOP;
      r_pc_plus4 <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_wr_reg   <= '0;
    end else if (ex_ready) begin
      r_valid    <= id_valid;
      r_ctrl     <= id_valid ? w_id_ctrl : CTRL_NOP;
      r_pc_plus4 <= id_pc_plus4;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_wr_reg   <= id_reg_dst ? id_rd : id_rt;
    end
  end
  assign ex_valid     = r_valid;
  assign ex_alu_op    = r_ctrl.alu_op;
  assign ex_reg_dst   = r_ctrl.reg_dst;
  assign ex_branch    = r_ctrl.branch;
  assign ex_mem_read  = r_ctrl.mem_read;
  assign ex_mem_2_reg = r_ctrl.mem_2_reg;
  assign ex_mem_write = r_ctrl.mem_write;
  assign ex_alu_src   = r_ctrl.alu_src;
  assign ex_reg_write = r_ctrl.reg_write;
  assign ex_jump      = r_ctrl.jump;
  assign ex_pc_plus4  = r_pc_plus4;
  assign ex_rs_data   = r_rs_data;
  assign ex_rt_data   = r_rt_data;
  assign ex_imm       = r_imm;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_wr_reg    = r_wr_reg;
`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_hazard && !flush && ex_ready && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && !(&perf_flush_cnt)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus randomized checks of id_ex_stage against a rule-level reference model
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, id_valid, flush, ex_ready;
  logic [9:0]  id_ctrl;
  logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        stall, ex_valid;
  logic [1:0]  ex_alu_op;
  logic        ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jump;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wr_reg;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
  logic [31:0] m_sc = '0, m_fc = '0;
`endif
  logic        m_valid = 1'b0;
  logic [9:0]  m_ctrl = '0;
  logic [31:0] m_pc = '0, m_rsd = '0, m_rtd = '0, m_imm = '0;
  logic [4:0]  m_rs = '0, m_rt = '0, m_wr = '0;
  int checks = 0;
  int failures = 0;
  localparam logic [9:0] C_ADDI = 10'h006;
  localparam logic [9:0] C_LW   = 10'h036;
  localparam logic [9:0] C_ADD  = 10'h282;
  localparam logic [9:0] C_SW   = 10'h00C;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_alu_op(id_ctrl[9:8]), .id_reg_dst(id_ctrl[7]), .id_branch(id_ctrl[6]), .id_mem_read(id_ctrl[5]),
    .id_mem_2_reg(id_ctrl[4]), .id_mem_write(id_ctrl[3]), .id_alu_src(id_ctrl[2]), .id_reg_write(id_ctrl[1]),
    .id_jump(id_ctrl[0]), .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .ex_ready(ex_ready),
    .stall(stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_2_reg(ex_mem_2_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_jump(ex_jump), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_reg(ex_wr_reg)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic f, input logic rdy);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; flush = f; ex_ready = rdy;
    id_pc_plus4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask
  // One clock: check stall before the edge, advance the model by the stage rules, check EX after the edge.
  task automatic step();
    logic h;
    h = id_valid && m_valid && m_ctrl[5] && m_wr != 5'd0 && (m_wr == id_rs || m_wr == id_rt);
    #1 chk("stall", 128'(stall), 128'(!flush && (h || !ex_ready)));
`ifdef ID_EX_PERF_CNT_EN
    if (rst) begin
      m_sc = '0; m_fc = '0;
    end else begin
      if (h && !flush && ex_ready && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (flush && m_fc != 32'hFFFF_FFFF) m_fc++;
    end
`endif
    if (rst || flush || (ex_ready && h)) begin
      m_valid = 0; m_ctrl = '0; m_pc = '0; m_rsd = '0; m_rtd = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_wr = '0;
    end else if (ex_ready) begin
      m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : 10'h0;
      m_pc = id_pc_plus4; m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_wr = id_ctrl[7] ? id_rd : id_rt;
    end
    @(posedge clk);
    #1;
    chk("ctrl", 128'({ex_valid, ex_alu_op, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_2_reg, ex_mem_write,
                      ex_alu_src, ex_reg_write, ex_jump}), 128'({m_valid, m_ctrl}));
    chk("data", {ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm}, {m_pc, m_rsd, m_rtd, m_imm});
    chk("idx", 128'({ex_rs, ex_rt, ex_wr_reg}), 128'({m_rs, m_rt, m_wr}));
`ifdef ID_EX_PERF_CNT_EN
    chk("perf", 128'({perf_stall_cnt, perf_flush_cnt}), 128'({m_sc, m_fc}));
`endif
  endtask
  initial begin
    rst = 1;
    drv(1, 10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 0, 1);
    @(posedge clk);
    #1;
    step();
    drv(1, 10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 0, 1);
    step();
    chk("reset_valid", 128'(ex_valid), 128'(0));
    rst = 0;
    drv(1, C_ADDI, 5'd1, 5'd5, 5'd7, 0, 1);
    id_imm = 32'h10;
    step();
    chk("addi", 128'({ex_reg_write, ex_wr_reg, ex_imm}), 128'({1'b1, 5'd5, 32'h10}));
    drv(1, C_LW, 5'd2, 5'd8, 5'd0, 0, 1);
    step();
    drv(1, C_ADD, 5'd8, 5'd3, 5'd9, 0, 1);
    step();
    chk("loaduse_bubble", 128'(ex_valid), 128'(0));
    step();
    chk("loaduse_capture", 128'({ex_valid, ex_rs, ex_wr_reg}), 128'({1'b1, 5'd8, 5'd9}));
    drv(1, C_LW, 5'd2, 5'd0, 5'd0, 0, 1);
    step();
    drv(1, C_ADD, 5'd0, 5'd0, 5'd9, 0, 1);
    step();
    chk("r0_no_stall", 128'(ex_valid), 128'(1));
    drv(1, C_SW, 5'd4, 5'd6, 5'd0, 1, 1);
    step();
    chk("flush_sw", 128'({ex_valid, ex_mem_write}), 128'(0));
    drv(1, C_LW, 5'd2, 5'd8, 5'd0, 0, 1);
    step();
    drv(1, C_ADD, 5'd8, 5'd3, 5'd9, 1, 1);
    step();
    chk("flush_hazard", 128'(ex_valid), 128'(0));
    drv(1, C_ADD, 5'd10, 5'd11, 5'd12, 0, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drv(1, 10'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 0, 0);
      step();
      chk("hold_wr", 128'(ex_wr_reg), 128'(12));
    end
    drv(1, C_ADDI, 5'd13, 5'd14, 5'd15, 0, 1);
    step();
    chk("release", 128'({ex_rs, ex_wr_reg}), 128'({5'd13, 5'd14}));
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 63) == 0;
      drv($urandom_range(0, 7) != 0, 10'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) id_ctrl[5] = 1'b1;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
